// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared types and constants for the pipeline run-control sequencer
//
// Contents:
//   run_state_t  run-control FSM state encoding (STEP is always reserved, even when unreachable)
//   SYS_HALT     syscall selector that ends the program
//   SYS_PAUSE    syscall selector that pauses until the continue key is pressed
//   trap_match   syscall-in-WB selector decode
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        RUN    = 3'd1,
        PAUSE  = 3'd2,
        RESUME = 3'd3,
        STEP   = 3'd4,
        HALT   = 3'd5
    } run_state_t;

    localparam logic [31:0] SYS_HALT  = 32'h0000_000A;
    localparam logic [31:0] SYS_PAUSE = 32'h0000_0032;

    function automatic logic trap_match(input logic valid, input logic [31:0] sel,
                                        input logic [31:0] code);
        return valid && (sel == code);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchroniser plus stability-counter debouncer emitting one pulse per press
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive identical synchronised samples needed to accept a new level (>=2)
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset; clears synchroniser, counter and accepted level
//   key_raw  in   raw asynchronous button, active-high
//   pulse    out  single-cycle pulse on an accepted rising edge
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic pulse
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    logic w_diff;
    logic w_accept;

    // r_cnt holds how many consecutive differing samples preceded this one, so the
    // sample that completes the run of DEBOUNCE_CYCLES is seen when r_cnt == LAST.
    assign w_diff   = r_sync2 != r_level;
    assign w_accept = w_diff && (r_cnt == LAST);
    assign pulse    = w_accept && r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= key_raw;
            r_sync2 <= r_sync1;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// rtl/pipeline_run_ctrl.sv - run-control sequencer driving the global pipeline freeze enable
//
// Optional feature macro: RUN_CTRL_STEP_EN (adds step_key and the PAUSE->STEP->PAUSE single-step path)
// Parameters:
//   DEBOUNCE_CYCLES  key debounce stability length
//   CNT_W            width of cycle_cnt
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   continue_key  in   raw continue button
//   step_key      in   raw single-step button (RUN_CTRL_STEP_EN only)
//   syscall_wb    in   syscall valid in WB
//   a0_wb         in   syscall selector value in WB
//   pipe_go       out  1 = stage buffers and PC advance this cycle
//   run_state     out  current FSM state encoding
//   halted        out  registered HALT decode
//   paused        out  registered PAUSE decode
//   cycle_cnt     out  saturating count of pipe_go cycles
//   pause_cnt     out  wrapping count of PAUSE entries
module pipeline_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             continue_key,
`ifdef RUN_CTRL_STEP_EN
    input  logic             step_key,
`endif
    input  logic             syscall_wb,
    input  logic [31:0]      a0_wb,
    output logic             pipe_go,
    output logic [2:0]       run_state,
    output logic             halted,
    output logic             paused,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [15:0]      pause_cnt
);

    run_state_t       r_state;
    run_state_t       w_state_next;
    logic             r_halted;
    logic             r_paused;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [15:0]      r_pause_cnt;

    logic w_trap_halt;
    logic w_trap_pause;
    logic w_pipe_go;
    logic w_pause_entry;
    logic w_cont_pulse;
    logic w_step_pulse;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cont_db (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_raw(continue_key),
        .pulse  (w_cont_pulse)
    );

`ifdef RUN_CTRL_STEP_EN
    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_raw(step_key),
        .pulse  (w_step_pulse)
    );
`else
    assign w_step_pulse = 1'b0;
`endif

    assign w_trap_halt  = trap_match(syscall_wb, a0_wb, SYS_HALT);
    assign w_trap_pause = trap_match(syscall_wb, a0_wb, SYS_PAUSE);

    // A trapping syscall freezes the pipe in the cycle it reaches WB, so it stays in WB
    // while paused; RESUME then forces one advance to move it out without re-trapping.
    always_comb begin
        w_state_next  = r_state;
        w_pipe_go     = 1'b0;
        w_pause_entry = 1'b0;
        case (r_state)
            INIT: begin
                w_state_next = RUN;
            end
            RUN: begin
                w_pipe_go = !(w_trap_halt || w_trap_pause);
                if (w_trap_halt) begin
                    w_state_next = HALT;
                end else if (w_trap_pause) begin
                    w_state_next  = PAUSE;
                    w_pause_entry = 1'b1;
                end
            end
            PAUSE: begin
                if (w_cont_pulse) begin
                    w_state_next = RESUME;
                end else if (w_step_pulse) begin
                    w_state_next = STEP;
                end
            end
            RESUME: begin
                w_pipe_go    = 1'b1;
                w_state_next = RUN;
            end
            STEP: begin
                w_pipe_go    = 1'b1;
                w_state_next = PAUSE;
            end
            HALT: begin
                w_state_next = HALT;
            end
            default: begin
                w_state_next = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= INIT;
            r_halted <= 1'b0;
            r_paused <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_halted <= (w_state_next == HALT);
            r_paused <= (w_state_next == PAUSE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= '0;
            r_pause_cnt <= '0;
        end else begin
            if (w_pipe_go && (r_cycle_cnt != {CNT_W{1'b1}})) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            if (w_pause_entry) begin
                r_pause_cnt <= r_pause_cnt + 16'd1;
            end
        end
    end

    assign pipe_go   = w_pipe_go;
    assign run_state = r_state;
    assign halted    = r_halted;
    assign paused    = r_paused;
    assign cycle_cnt = r_cycle_cnt;
    assign pause_cnt = r_pause_cnt;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// tb/tb_pipeline_run_ctrl.sv - self-checking bench for pipeline_run_ctrl with a cycle reference model
module tb_pipeline_run_ctrl;
    import run_ctrl_pkg::*;

    localparam int D = 6;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b0;
    logic        continue_key = 1'b0;
    logic        step_key     = 1'b0;
    logic        syscall_wb   = 1'b0;
    logic [31:0] a0_wb        = 32'h0;

    logic        pipe_go;
    logic [2:0]  run_state;
    logic        halted;
    logic        paused;
    logic [31:0] cycle_cnt;
    logic [15:0] pause_cnt;

    logic        s_pipe_go;
    logic [2:0]  s_run_state;
    logic        s_halted;
    logic        s_paused;
    logic [3:0]  s_cycle_cnt;
    logic [15:0] s_pause_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_run_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .continue_key(continue_key),
`ifdef RUN_CTRL_STEP_EN
        .step_key(step_key),
`endif
        .syscall_wb(syscall_wb), .a0_wb(a0_wb), .pipe_go(pipe_go), .run_state(run_state),
        .halted(halted), .paused(paused), .cycle_cnt(cycle_cnt), .pause_cnt(pause_cnt)
    );

    pipeline_run_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .continue_key(continue_key),
`ifdef RUN_CTRL_STEP_EN
        .step_key(step_key),
`endif
        .syscall_wb(syscall_wb), .a0_wb(a0_wb), .pipe_go(s_pipe_go), .run_state(s_run_state),
        .halted(s_halted), .paused(s_paused), .cycle_cnt(s_cycle_cnt), .pause_cnt(s_pause_cnt)
    );

    // Reference model: raw key history since reset, accepted key levels, run mode and counts.
    run_state_t m_state = INIT;
    longint     m_cyc   = 0;
    int         m_pc    = 0;
    bit         m_acc_c = 1'b0;
    bit         m_acc_s = 1'b0;
    bit         m_valid = 1'b0;
    bit         h_c[$];
    bit         h_s[$];

    // True when the D most recent synchronised samples (raw delayed two cycles, 0 right after reset) all equal lvl.
    function automatic bit run_is(input bit is_step, input bit lvl);
        int c;
        bit s;
        c = is_step ? h_s.size() : h_c.size();
        if (c < D - 1) return 1'b0;
        for (int k = c - D + 1; k <= c; k++) begin
            if (k < 2) s = 1'b0;
            else       s = is_step ? h_s[k-2] : h_c[k-2];
            if (s != lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit model_go();
        bit trap;
        trap = syscall_wb && ((a0_wb == 32'hA) || (a0_wb == 32'h32));
        case (m_state)
            RUN:          return !trap;
            RESUME, STEP: return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit cp, sp, th, tp;
        if (!rst_n) begin
            m_state = INIT; m_cyc = 0; m_pc = 0; m_acc_c = 0; m_acc_s = 0;
            h_c.delete(); h_s.delete();
            m_valid = 1'b1;
        end else begin
            cp = 1'b0;
            sp = 1'b0;
            if (run_is(1'b0, !m_acc_c)) begin m_acc_c = !m_acc_c; cp = m_acc_c; end
`ifdef RUN_CTRL_STEP_EN
            if (run_is(1'b1, !m_acc_s)) begin m_acc_s = !m_acc_s; sp = m_acc_s; end
`endif
            th = syscall_wb && (a0_wb == 32'hA);
            tp = syscall_wb && (a0_wb == 32'h32);
            if (model_go()) m_cyc++;
            case (m_state)
                INIT:   m_state = RUN;
                RUN:    if (th) m_state = HALT; else if (tp) begin m_state = PAUSE; m_pc++; end
                PAUSE:  if (cp) m_state = RESUME; else if (sp) m_state = STEP;
                RESUME: m_state = RUN;
                STEP:   m_state = PAUSE;
                default: m_state = m_state;
            endcase
            h_c.push_back(continue_key);
            h_s.push_back(step_key);
        end
    end

    always @(negedge clk) begin : monitor
        logic [31:0] e32;
        logic [3:0]  e4;
        if (m_valid) begin
            e32 = (m_cyc > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : m_cyc[31:0];
            e4  = (m_cyc > 15) ? 4'hF : m_cyc[3:0];
            n_tests++;
            if (pipe_go !== model_go()) begin n_fail++; $display("FAIL mon_pipe_go t=%0t got %b exp %b", $time, pipe_go, model_go()); end
            n_tests++;
            if (run_state !== m_state) begin n_fail++; $display("FAIL mon_state t=%0t got %0d exp %0d", $time, run_state, m_state); end
            n_tests++;
            if (halted !== (m_state == HALT)) begin n_fail++; $display("FAIL mon_halted t=%0t got %b exp %b", $time, halted, m_state == HALT); end
            n_tests++;
            if (paused !== (m_state == PAUSE)) begin n_fail++; $display("FAIL mon_paused t=%0t got %b exp %b", $time, paused, m_state == PAUSE); end
            n_tests++;
            if (cycle_cnt !== e32) begin n_fail++; $display("FAIL mon_cycle_cnt t=%0t got %0d exp %0d", $time, cycle_cnt, e32); end
            n_tests++;
            if (pause_cnt !== m_pc[15:0]) begin n_fail++; $display("FAIL mon_pause_cnt t=%0t got %0d exp %0d", $time, pause_cnt, m_pc[15:0]); end
            n_tests++;
            if (s_cycle_cnt !== e4) begin n_fail++; $display("FAIL mon_sat_cnt t=%0t got %0d exp %0d", $time, s_cycle_cnt, e4); end
            n_tests++;
            if (s_pipe_go !== model_go()) begin n_fail++; $display("FAIL mon_sat_go t=%0t got %b exp %b", $time, s_pipe_go, model_go()); end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; continue_key = 1'b0; step_key = 1'b0; syscall_wb = 1'b0; a0_wb = 32'h0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic enter_pause();
        syscall_wb = 1'b1; a0_wb = 32'h32;
        step();
        syscall_wb = 1'b0; a0_wb = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        #3;
        n_tests++;
        if (run_state !== 3'd0 || pipe_go !== 1'b0 || halted !== 1'b0 || paused !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: state %0d go %b halted %b paused %b, required 0 0 0 0", run_state, pipe_go, halted, paused);
        end
        n_tests++;
        if (cycle_cnt !== 32'd0 || pause_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_counts: cycle %0d pause %0d, required 0 0", cycle_cnt, pause_cnt);
        end
        step();
    endtask

    task automatic test_run();
        rst_n = 1'b1;
        #3;
        n_tests++;
        if (pipe_go !== 1'b0) begin n_fail++; $display("FAIL run_cycle0_go: got %b required 0", pipe_go); end
        step();
        #3;
        n_tests++;
        if (pipe_go !== 1'b1 || run_state !== 3'd1) begin n_fail++; $display("FAIL run_cycle1: go %b state %0d, required 1 1", pipe_go, run_state); end
        repeat (10) step();
        #3;
        n_tests++;
        if (cycle_cnt !== 32'd10) begin n_fail++; $display("FAIL run_cnt10: got %0d required 10", cycle_cnt); end
        step();
    endtask

    task automatic test_halt();
        int k;
        k = $urandom_range(2, 8);
        do_reset();
        repeat (k) step();
        syscall_wb = 1'b1; a0_wb = 32'hA;
        #3;
        n_tests++;
        if (pipe_go !== 1'b0) begin n_fail++; $display("FAIL halt_go_same_cycle: got %b required 0", pipe_go); end
        step();
        syscall_wb = 1'b0; a0_wb = 32'h0;
        #3;
        n_tests++;
        if (halted !== 1'b1 || run_state !== 3'd5) begin n_fail++; $display("FAIL halt_next: halted %b state %0d, required 1 5", halted, run_state); end
        repeat (40) step();
        continue_key = 1'b1;
        repeat (D + 10) step();
        continue_key = 1'b0;
        repeat (D + 5) step();
        #3;
        n_tests++;
        if (run_state !== 3'd5 || pipe_go !== 1'b0) begin n_fail++; $display("FAIL halt_terminal: state %0d go %b, required 5 0", run_state, pipe_go); end
        n_tests++;
        if (cycle_cnt !== 32'(k - 1)) begin n_fail++; $display("FAIL halt_cnt_frozen: got %0d required %0d", cycle_cnt, k - 1); end
        step();
    endtask

    task automatic test_pause_debounce();
        do_reset();
        repeat (4) step();
        syscall_wb = 1'b1; a0_wb = 32'h32;
        #3;
        n_tests++;
        if (pipe_go !== 1'b0) begin n_fail++; $display("FAIL pause_go_same_cycle: got %b required 0", pipe_go); end
        step();
        syscall_wb = 1'b0; a0_wb = 32'h0;
        #3;
        n_tests++;
        if (paused !== 1'b1 || pause_cnt !== 16'd1) begin n_fail++; $display("FAIL pause_entry: paused %b cnt %0d, required 1 1", paused, pause_cnt); end
        repeat (5) step();
        for (int b = 0; b < 3; b++) begin
            continue_key = 1'b1; step(); step();
            continue_key = 1'b0; step(); step();
        end
        continue_key = 1'b1;
        for (int i = 0; i < D + 2; i++) begin
            #3;
            n_tests++;
            if (pipe_go !== 1'b0 || run_state !== 3'd2) begin n_fail++; $display("FAIL pause_hold_%0d: go %b state %0d, required 0 2", i, pipe_go, run_state); end
            step();
        end
        #3;
        n_tests++;
        if (pipe_go !== 1'b1 || run_state !== 3'd3) begin n_fail++; $display("FAIL resume_cycle: go %b state %0d, required 1 3", pipe_go, run_state); end
        step();
        #3;
        n_tests++;
        if (run_state !== 3'd1) begin n_fail++; $display("FAIL resume_to_run: state %0d required 1", run_state); end
        repeat (20) step();
        #3;
        n_tests++;
        if (run_state !== 3'd1 || pause_cnt !== 16'd1) begin n_fail++; $display("FAIL held_key_single_pulse: state %0d cnt %0d, required 1 1", run_state, pause_cnt); end
        continue_key = 1'b0;
        repeat (D + 4) step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        repeat (3) step();
        syscall_wb = 1'b1; a0_wb = 32'h32;
        step();
        continue_key = 1'b1;
        #3;
        n_tests++;
        if (pipe_go !== 1'b0 || paused !== 1'b1) begin n_fail++; $display("FAIL b2b_paused: go %b paused %b, required 0 1", pipe_go, paused); end
        repeat (D + 2) step();
        #3;
        n_tests++;
        if (pipe_go !== 1'b1 || run_state !== 3'd3) begin n_fail++; $display("FAIL b2b_resume: go %b state %0d, required 1 3", pipe_go, run_state); end
        step();
        a0_wb = 32'hA;
        #3;
        n_tests++;
        if (pipe_go !== 1'b0) begin n_fail++; $display("FAIL b2b_halt_go: got %b required 0", pipe_go); end
        step();
        syscall_wb = 1'b0; a0_wb = 32'h0; continue_key = 1'b0;
        #3;
        n_tests++;
        if (halted !== 1'b1 || pause_cnt !== 16'd1) begin n_fail++; $display("FAIL b2b_halted: halted %b cnt %0d, required 1 1", halted, pause_cnt); end
        step();
    endtask

`ifdef RUN_CTRL_STEP_EN
    task automatic test_step();
        int          gos;
        int          adj;
        bit          prev;
        logic [31:0] c0;
        do_reset();
        repeat (3) step();
        enter_pause();
        #3;
        c0   = cycle_cnt;
        gos  = 0;
        adj  = 0;
        prev = 1'b0;
        step();
        for (int p = 0; p < 3; p++) begin
            for (int lvl = 1; lvl >= 0; lvl--) begin
                step_key = lvl[0];
                repeat (D + 4) begin
                    #3;
                    if (pipe_go === 1'b1) begin gos++; if (prev) adj++; end
                    prev = (pipe_go === 1'b1);
                    step();
                end
            end
        end
        #3;
        n_tests++;
        if (gos != 3 || adj != 0) begin n_fail++; $display("FAIL step_pulses: go cycles %0d adjacent %0d, required 3 0", gos, adj); end
        n_tests++;
        if (cycle_cnt - c0 !== 32'd3 || paused !== 1'b1) begin n_fail++; $display("FAIL step_cnt: delta %0d paused %b, required 3 1", cycle_cnt - c0, paused); end
        step();
        continue_key = 1'b1; step_key = 1'b1;
        repeat (D + 2) step();
        #3;
        n_tests++;
        if (run_state !== 3'd3) begin n_fail++; $display("FAIL step_cont_priority: state %0d required 3", run_state); end
        step();
        continue_key = 1'b0; step_key = 1'b0;
        repeat (D + 4) step();
    endtask
`endif

    task automatic test_saturate_and_reset();
        do_reset();
        repeat (20) step();
        #3;
        n_tests++;
        if (s_cycle_cnt !== 4'hF || cycle_cnt !== 32'd19) begin n_fail++; $display("FAIL saturate: sat %0d wide %0d, required 15 19", s_cycle_cnt, cycle_cnt); end
        step();
        enter_pause();
        continue_key = 1'b1;
        step(); step();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (run_state !== 3'd0 || paused !== 1'b0 || s_run_state !== 3'd0) begin n_fail++; $display("FAIL midpause_reset_state: state %0d paused %b, required 0 0", run_state, paused); end
        n_tests++;
        if (cycle_cnt !== 32'd0 || s_cycle_cnt !== 4'd0 || pause_cnt !== 16'd0 || s_pause_cnt !== 16'd0) begin
            n_fail++; $display("FAIL midpause_reset_cnt: cycle %0d sat %0d pause %0d, required 0 0 0", cycle_cnt, s_cycle_cnt, pause_cnt);
        end
        step();
        continue_key = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            syscall_wb = ($urandom_range(0, 99) < 6);
            case ($urandom_range(0, 2))
                0:       a0_wb = 32'hA;
                1:       a0_wb = 32'h32;
                default: a0_wb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) continue_key = ~continue_key;
            if ($urandom_range(0, 9) == 0) step_key = ~step_key;
            if ((m_state == HALT && $urandom_range(0, 29) == 0) || $urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            step();
        end
        syscall_wb = 1'b0;
        #3;
        n_tests++;
        if (pause_cnt !== m_pc[15:0]) begin n_fail++; $display("FAIL random_pause_cnt: got %0d required %0d", pause_cnt, m_pc[15:0]); end
        step();
    endtask

    initial begin
        test_reset();
        test_run();
        test_halt();
        test_pause_debounce();
        test_back_to_back();
`ifdef RUN_CTRL_STEP_EN
        test_step();
`endif
        test_saturate_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

endmodule
